// File: rtl/alu_cmd_scheduler_if.sv
// Bus between the requesting engines, the scheduler and the shared cascaded_alu.
// slave  : the scheduler's view (requests/ALU status in, grants/responses/ALU controls out).
// master : the environment's view (requesters plus ALU).
interface alu_cmd_scheduler_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 32
);
  // requester side
  logic                    req0;
  logic                    req1;
  logic [DATA_WIDTH-1:0]   a0;
  logic [DATA_WIDTH-1:0]   b0;
  logic [DATA_WIDTH-1:0]   a1;
  logic [DATA_WIDTH-1:0]   b1;
  logic [2:0]              op0;
  logic [2:0]              op1;
  logic                    gnt0;
  logic                    gnt1;

  // response side
  logic                    rsp_valid;
  logic                    rsp_id;
  logic [RESULT_WIDTH-1:0] rsp_result;
  logic                    rsp_err;
  logic                    busy;

  // cascaded_alu side
  logic [DATA_WIDTH-1:0]   alu_a;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic [2:0]              alu_op;
  logic                    alu_start;
  logic                    alu_end;
  logic [RESULT_WIDTH-1:0] alu_result;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1,
    input  alu_end, alu_result,
    output gnt0, gnt1,
    output rsp_valid, rsp_id, rsp_result, rsp_err, busy,
    output alu_a, alu_b, alu_op, alu_start
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1,
    output alu_end, alu_result,
    input  gnt0, gnt1,
    input  rsp_valid, rsp_id, rsp_result, rsp_err, busy,
    input  alu_a, alu_b, alu_op, alu_start
  );
endinterface

// File: rtl/alu_cmd_scheduler.sv
// Two-requester round-robin command scheduler in front of a single cascaded_alu.
// Runs one operation at a time: capture, one-cycle start pulse, hold operands
// until end_op, then return the result tagged with the requester id.
// Optional WAIT watchdog enabled by defining ALU_SCHED_TIMEOUT_EN; without it
// rsp_err is constant 0 and WAIT holds until alu_end.
//
// state  | meaning
// IDLE   | no command in flight; a request at the edge is captured and granted
// ISSUE  | alu_start high for this single cycle
// WAIT   | operands held, waiting for alu_end (or watchdog expiry)
module alu_cmd_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int RESULT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic             clk,
  input logic             rst,
  alu_cmd_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    owner_q, owner_d;
  logic                    win;

  logic                    gnt0_q, gnt0_d;
  logic                    gnt1_q, gnt1_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_id_q, rsp_id_d;
  logic [RESULT_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [2:0]              alu_op_q, alu_op_d;
  logic                    alu_start_q, alu_start_d;

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]           wait_cnt_q, wait_cnt_d;
`endif

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    win          = 1'b0;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_start_d  = 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester that was not granted last wins.
          win         = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          last_d      = win;
          owner_d     = win;
          gnt0_d      = ~win;
          gnt1_d      = win;
          alu_a_d     = win ? bus.a1  : bus.a0;
          alu_b_d     = win ? bus.b1  : bus.b0;
          alu_op_d    = win ? bus.op1 : bus.op0;
          alu_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ALU_SCHED_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      S_WAIT: begin
        // A real completion wins over a watchdog expiry in the same cycle.
        if (bus.alu_end) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = owner_q;
          rsp_result_d = bus.alu_result;
          rsp_err_d    = 1'b0;
          state_d      = S_IDLE;
        end
`ifdef ALU_SCHED_TIMEOUT_EN
        else if (wait_cnt_q == CNT_LAST) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = owner_q;
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          state_d      = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 3'd0;
      alu_start_q  <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_start_q  <= alu_start_d;
`ifdef ALU_SCHED_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_start  = alu_start_q;

endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Bench for alu_cmd_scheduler: behavioural ALU stub, randomized round-robin
// traffic checked against a transaction-level model of grant order, latency and result.
module tb_alu_cmd_scheduler;
  localparam int DW = 16;
  localparam int RW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   n_gnt = 0;
  int   exp_grants = 0;
  int   last_gnt = 1;
  logic stub_end = 1'b0;
  logic force_end = 1'b0;
  logic stall = 1'b0;
  int   stub_cnt = 0;

  alu_cmd_scheduler_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW)) bus ();

  alu_cmd_scheduler #(
    .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [RW-1:0] ea, eb;
    ea = RW'(a);
    eb = RW'(b);
    case (op)
      3'd0:    return ea * eb;
      3'd1:    return ea + eb;
      3'd2:    return ea - eb;
      3'd3:    return ea & eb;
      3'd4:    return ea | eb;
      3'd5:    return ea ^ eb;
      3'd6:    return ea;
      default: return eb;
    endcase
  endfunction

  // ALU stub: end_op one cycle after start, three cycles after for multiply.
  assign bus.alu_end    = stub_end | force_end;
  assign bus.alu_result = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  always @(negedge clk) begin
    stub_end = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0 && !stall) stub_end = 1'b1;
    end
    if (bus.alu_start) stub_cnt = (bus.alu_op == 3'd0) ? 3 : 1;
  end

  // Cycle-level invariants.
  always @(negedge clk) begin
    chk("gnt_onehot", 64'(bus.gnt0 & bus.gnt1), 0);
    chk("rsp_with_start", 64'(bus.rsp_valid & bus.alu_start), 0);
    if (bus.alu_start) n_start++;
    if (bus.gnt0 | bus.gnt1) n_gnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic set_req(input int id, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    if (id == 0) begin
      bus.req0 = 1'b1; bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = 1'b1; bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end
  endtask

  task automatic drop_req(input int id);
    if (id == 0) bus.req0 = 1'b0;
    else         bus.req1 = 1'b0;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_gnt0"},       bus.gnt0, 0);
    chk({pfx, "_gnt1"},       bus.gnt1, 0);
    chk({pfx, "_rsp_valid"},  bus.rsp_valid, 0);
    chk({pfx, "_rsp_id"},     bus.rsp_id, 0);
    chk({pfx, "_rsp_result"}, bus.rsp_result, 0);
    chk({pfx, "_rsp_err"},    bus.rsp_err, 0);
    chk({pfx, "_busy"},       bus.busy, 0);
    chk({pfx, "_alu_a"},      bus.alu_a, 0);
    chk({pfx, "_alu_b"},      bus.alu_b, 0);
    chk({pfx, "_alu_op"},     bus.alu_op, 0);
    chk({pfx, "_alu_start"},  bus.alu_start, 0);
  endtask

  // Waits for one grant of the expected requester and its response.
  task automatic serve(input int id, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input int exp_gnt_cyc, output int rsp_cyc);
    bit got;
    int gcyc;
    rsp_cyc = cyc;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.gnt0 | bus.gnt1) begin got = 1'b1; break; end
    end
    chk("gnt_seen", 64'(got), 1);
    if (!got) return;
    gcyc = cyc;
    exp_grants++;
    chk("gnt_id", {bus.gnt1, bus.gnt0}, (id == 1) ? 2'b10 : 2'b01);
    chk("gnt_cycle", gcyc, exp_gnt_cyc);
    chk("start_at_gnt", bus.alu_start, 1);
    chk("busy_at_gnt", bus.busy, 1);
    drop_req(id);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.rsp_valid) begin got = 1'b1; break; end
      chk("alu_hold", {bus.alu_op, bus.alu_a, bus.alu_b}, {op, a, b});
      @(negedge clk);
    end
    chk("rsp_seen", 64'(got), 1);
    if (!got) return;
    rsp_cyc = cyc;
    chk("rsp_cycle", cyc, gcyc + ((op == 3'd0) ? 4 : 2));
    chk("rsp_id", bus.rsp_id, id);
    chk("rsp_result", bus.rsp_result, alu_ref(op, a, b));
    chk("rsp_err", bus.rsp_err, 0);
    chk("busy_at_rsp", bus.busy, 0);
  endtask

  // One arbitration round: requesters raise together, model predicts order.
  task automatic round(input bit r0, input bit r1,
                       input logic [2:0] op0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic [2:0] op1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
    int w, t, rc, rc2;
    @(negedge clk);
    t = cyc;
    if (r0) set_req(0, op0, a0, b0);
    if (r1) set_req(1, op1, a1, b1);
    w = (r0 && r1) ? (1 - last_gnt) : (r1 ? 1 : 0);
    if (w == 0) serve(0, op0, a0, b0, t + 1, rc);
    else        serve(1, op1, a1, b1, t + 1, rc);
    last_gnt = w;
    if (r0 && r1) begin
      if (w == 0) serve(1, op1, a1, b1, rc + 1, rc2);
      else        serve(0, op0, a0, b0, rc + 1, rc2);
      last_gnt = 1 - w;
    end
  endtask

  initial begin
    int t, g, seen;
    bit got;
    logic [2:0] rop0, rop1;
    logic [1:0] sel;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.op0 = 3'd0; bus.op1 = 3'd0;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // Both requesters contending from reset: order 0,1,0,1.
    round(1'b1, 1'b1, 3'd1, 16'd10, 16'd20, 3'd5, 16'h1234, 16'h00ff);
    round(1'b1, 1'b1, 3'd0, 16'd7, 16'd9, 3'd3, 16'hf0f0, 16'h3c3c);

    round(1'b1, 1'b0, 3'd1, 16'd3, 16'd5, 3'd0, 16'd0, 16'd0);
    chk("tp_add_result", bus.rsp_result, 32'h0000_0008);
    round(1'b0, 1'b1, 3'd0, 16'd0, 16'd0, 3'd0, 16'h0003, 16'h0004);
    chk("tp_mul_result", bus.rsp_result, 32'h0000_000c);
    chk("tp_mul_id", bus.rsp_id, 1);
    round(1'b1, 1'b0, 3'd4, 16'h00f0, 16'h0f00, 3'd0, 16'd0, 16'd0);
    chk("tp_or_result", bus.rsp_result, 32'h0000_0ff0);

    for (int i = 0; i < 40; i++) begin
      sel  = 2'($urandom_range(1, 3));
      rop0 = 3'($urandom_range(0, 7));
      rop1 = 3'($urandom_range(0, 7));
      round(sel[0], sel[1], rop0, 16'($urandom), 16'($urandom),
            rop1, 16'($urandom), 16'($urandom));
    end

    // ALU never answers on its own.
    stall = 1'b1;
    @(negedge clk);
    set_req(1, 3'd2, 16'h0077, 16'h0011);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.gnt1) begin got = 1'b1; break; end
    end
    chk("stall_gnt1", 64'(got), 1);
    g = cyc;
    exp_grants++;
    drop_req(1);
`ifdef ALU_SCHED_TIMEOUT_EN
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin got = 1'b1; break; end
    end
    chk("to_rsp_seen", 64'(got), 1);
    chk("to_rsp_cycle", cyc, g + TO + 1);
    chk("to_rsp_err", bus.rsp_err, 1);
    chk("to_rsp_result", bus.rsp_result, 0);
    chk("to_rsp_id", bus.rsp_id, 1);
    stall = 1'b0;
    @(negedge clk); force_end = 1'b1;
    @(negedge clk); force_end = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.rsp_valid) seen++;
      @(negedge clk);
    end
    chk("late_end_ignored", seen, 0);
`else
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("stall_no_rsp", seen, 0);
    chk("stall_busy", bus.busy, 1);
    chk("stall_err", bus.rsp_err, 0);
    stall = 1'b0;
    force_end = 1'b1;
    @(negedge clk); force_end = 1'b0;
    chk("stall_rsp_valid", bus.rsp_valid, 1);
    chk("stall_rsp_result", bus.rsp_result, alu_ref(3'd2, 16'h0077, 16'h0011));
    chk("stall_rsp_err", bus.rsp_err, 0);
`endif
    last_gnt = 1;

    // Reset in the middle of a multiply.
    @(negedge clk);
    set_req(0, 3'd0, 16'h0101, 16'h0202);
    t = cyc;
    @(negedge clk);
    chk("rst_gnt0", bus.gnt0, 1);
    exp_grants++;
    drop_req(0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_cycle", cyc, t + 3);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_zero("midrst");
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.rsp_valid) seen++;
      @(negedge clk);
    end
    chk("midrst_no_rsp", seen, 0);
    last_gnt = 1;
    round(1'b1, 1'b0, 3'd1, 16'd100, 16'd23, 3'd0, 16'd0, 16'd0);
    chk("post_rst_result", bus.rsp_result, 32'd123);

    repeat (2) @(negedge clk);
    chk("start_count", n_start, exp_grants);
    chk("gnt_count", n_gnt, exp_grants);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
